// File: rtl/tick_prescaler_if.sv
//------------------------------------------------------------------------------
// Module   : tick_prescaler_if
// Brief    : Control/status bundle between a tick_prescaler and its host.
//            The phase signal exists only when TICK_PHASE_OUT_EN is defined.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tick_prescaler_if #(
    parameter int WIDTH   = 8,
    parameter int BURST_W = 4
);
    logic               div_load;
    logic [WIDTH-1:0]   div_value;
    logic               mode;
    logic [BURST_W-1:0] burst_len;
    logic               start;
    logic               stop;
    logic               tick;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   div_q;
`ifdef TICK_PHASE_OUT_EN
    logic               phase;
`endif

    modport master (
        output div_load, div_value, mode, burst_len, start, stop,
`ifdef TICK_PHASE_OUT_EN
        input  phase,
`endif
        input  tick, busy, done, div_q
    );

    modport slave (
        input  div_load, div_value, mode, burst_len, start, stop,
`ifdef TICK_PHASE_OUT_EN
        output phase,
`endif
        output tick, busy, done, div_q
    );
endinterface

`default_nettype wire

// File: rtl/tick_prescaler.sv
//------------------------------------------------------------------------------
// Module   : tick_prescaler
// Brief    : Programmable clock-enable generator with free-run and burst modes.
//            Define TICK_PHASE_OUT_EN to add a phase output toggling per tick.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 10,
    parameter int BURST_W     = 4
) (
    input  wire logic        CLK,
    input  wire logic        Reset,
    tick_prescaler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   C_DIV_RST   = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0]   C_ONE       = WIDTH'(1);
    localparam logic [BURST_W:0]   C_BURST_MAX = {1'b1, {BURST_W{1'b0}}};
    localparam logic [BURST_W:0]   C_BURST_ONE = (BURST_W+1)'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ratio_q, ratio_d;
    logic [WIDTH-1:0]   cnt_q,   cnt_d;
    logic [BURST_W:0]   burst_q, burst_d;
    logic               mode_q,  mode_d;
    logic               tick_q,  tick_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
`ifdef TICK_PHASE_OUT_EN
    logic               phase_q, phase_d;
`endif

    logic [WIDTH-1:0]   w_div_eff;
    logic [WIDTH-1:0]   w_start_eff;

    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] v);
        return (v == '0) ? C_ONE : v;
    endfunction

    assign w_div_eff   = eff_div(ratio_q);
    // A load coinciding with start must govern the very first period.
    assign w_start_eff = bus.div_load ? eff_div(bus.div_value) : w_div_eff;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ratio_q <= C_DIV_RST;
            cnt_q   <= '0;
            burst_q <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TICK_PHASE_OUT_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TICK_PHASE_OUT_EN
            phase_q <= phase_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ratio_d = bus.div_load ? bus.div_value : ratio_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
`ifdef TICK_PHASE_OUT_EN
        phase_d = phase_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    burst_d = (bus.burst_len == '0) ? C_BURST_MAX
                                                    : {1'b0, bus.burst_len};
                    cnt_d   = w_start_eff - C_ONE;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    tick_d = 1'b1;
                    cnt_d  = w_div_eff - C_ONE;
`ifdef TICK_PHASE_OUT_EN
                    phase_d = ~phase_q;
`endif
                    if (mode_q) begin
                        if (burst_q == C_BURST_ONE) begin
                            burst_d = '0;
                            state_d = ST_DONE;
                        end else begin
                            burst_d = burst_q - C_BURST_ONE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            ST_DONE: begin
                // The done pulse lands in the cycle right after the final tick.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    assign bus.tick  = tick_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.div_q = ratio_q;
`ifdef TICK_PHASE_OUT_EN
    assign bus.phase = phase_q;
`endif

endmodule

`default_nettype wire
